alu_control_md: RTL and testbench

- Parametrised successor to the single-cycle ALU control decoder.
- Decodes ALUOp/Funct into the 4-bit ALU Operation code, with the R-type set extended to xor, nor and sltu.
- Adds an iterative multiply/divide sequencer with HI/LO registers for MULT/MULTU/DIV/DIVU and MFHI/MFLO.
- Sits between the main control unit and the ALU. Drives `stall` to the PC/pipeline control while a multiply/divide is in flight.

---
 rtl/alu_control_md.sv | 255 +++++++++++++++++++++++++
 tb/tb_alu_control_md.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_md.sv
// alu_control_md: ALU control decoder with an iterative multiply/divide
// sequencer and HI/LO registers.
//
// Parameters:
//   WIDTH  - operand and HI/LO width
//   REG_OP - 0: Operation is combinational, 1: Operation is registered
//            (one cycle of latency, reset value 4'b1111)
//
// Optional build macro: MD_EARLY_OUT_EN
//   When defined, a multiply finishes as soon as the remaining multiplier
//   bits are all zero (1..WIDTH cycles). Divide always takes WIDTH cycles.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid             ALUOp/Funct/a/b carry a live instruction
//   ALUOp, Funct      operation class and funct field from main control
//   a, b              rs / rt operands
//   Operation         4-bit ALU operation code
//   md_sel            writeback select: 00 ALU, 01 HI, 10 LO
//   stall             hold the current instruction in place
//   md_busy           sequencer running
//   md_done           one-cycle pulse after HI/LO are updated
//   hi, lo            HI/LO registers
module alu_control_md #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_OP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       Operation,
  output logic [1:0]       md_sel,
  output logic             stall,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // partial product high half / remainder
  logic [WIDTH-1:0] lsr_q, lsr_d;     // multiplier+product low / dividend+quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;   // |multiplicand| or |divisor|
  logic             mul_q, mul_d;
  logic             neg_q, neg_d;     // negate product / quotient
  logic             rneg_q, rneg_d;   // negate remainder
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [3:0] op_c;
  logic       alu_r_c, is_md_c, is_mf_c, start_c;

  // Operation decode; every ALUOp/Funct combination has a defined code.
  always_comb begin
    op_c = 4'b1111;
    case (ALUOp)
      2'b00: op_c = 4'b0010;
      2'b01: op_c = 4'b0110;
      2'b10: begin
        case (Funct)
          6'b100000, 6'b100001: op_c = 4'b0010;
          6'b100010, 6'b100011: op_c = 4'b0110;
          6'b100100:            op_c = 4'b0000;
          6'b100101:            op_c = 4'b0001;
          6'b100110:            op_c = 4'b0011;
          6'b100111:            op_c = 4'b1100;
          6'b101010:            op_c = 4'b0111;
          6'b101011:            op_c = 4'b1000;
          default:              op_c = 4'b1111;
        endcase
      end
      default: op_c = 4'b1111;
    endcase
  end

  generate
    if (REG_OP != 0) begin : g_op_reg
      logic [3:0] op_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_q <= 4'b1111;
        else        op_q <= op_c;
      end
      assign Operation = op_q;
    end else begin : g_op_comb
      assign Operation = op_c;
    end
  endgenerate

  // Writeback select for MFHI / MFLO.
  always_comb begin
    md_sel = 2'b00;
    if (ALUOp == 2'b10) begin
      if (Funct == 6'b010000)      md_sel = 2'b01;
      else if (Funct == 6'b010010) md_sel = 2'b10;
    end
  end

  assign alu_r_c = (ALUOp == 2'b10);
  assign is_md_c = (Funct[5:2] == 4'b0110);  // MULT/MULTU/DIV/DIVU
  assign is_mf_c = (Funct == 6'b010000) || (Funct == 6'b010010);
  assign start_c = valid && alu_r_c && is_md_c && (state_q == S_IDLE);
  assign md_busy = (state_q == S_RUN);
  // The issuing mult/div stalls in its start cycle too, so it retires once.
  assign stall   = valid && alu_r_c && (is_md_c || is_mf_c) && (md_busy || start_c);

  // Operand magnitudes and sign flags captured at start (Funct[0]=0: signed).
  logic             sa_c, sb_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c;
  assign sa_c    = ~Funct[0] & a[WIDTH-1];
  assign sb_c    = ~Funct[0] & b[WIDTH-1];
  assign abs_a_c = sa_c ? -a : a;
  assign abs_b_c = sb_c ? -b : b;

  // One radix-2 shift-add multiply step.
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH-1:0] mul_acc_c, mul_lsr_c;
  assign mul_sum_c = {1'b0, acc_q} + (lsr_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_acc_c = mul_sum_c[WIDTH:1];
  assign mul_lsr_c = {mul_sum_c[0], lsr_q[WIDTH-1:1]};

  // One restoring-divide step; a zero divisor yields all-ones quotient, remainder = dividend.
  logic [WIDTH:0]   div_shift_c, div_diff_c;
  logic             qbit_c;
  logic [WIDTH-1:0] div_acc_c, div_lsr_c;
  assign div_shift_c = {acc_q, lsr_q[WIDTH-1]};
  assign div_diff_c  = div_shift_c - {1'b0, opnd_q};
  assign qbit_c      = ~div_diff_c[WIDTH];
  assign div_acc_c   = qbit_c ? div_diff_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0];
  assign div_lsr_c   = {lsr_q[WIDTH-2:0], qbit_c};

  logic          last_c, early_c, finish_c;
  logic [PW-1:0] prod_raw_c, prod_c;
  assign last_c     = (cnt_q == CW'(WIDTH - 1));
  assign prod_raw_c = {mul_acc_c, mul_lsr_c};

`ifdef MD_EARLY_OUT_EN
  // Remaining multiplier bits sit in the low WIDTH-steps bits of lsr; once
  // they are zero the product only needs the outstanding right shift.
  int unsigned      steps_c;
  logic [WIDTH-1:0] rem_mask_c;
  assign steps_c    = 32'(cnt_q) + 32'd1;
  assign rem_mask_c = {WIDTH{1'b1}} >> steps_c;
  assign early_c    = mul_q && ((mul_lsr_c & rem_mask_c) == '0);
  assign prod_c     = prod_raw_c >> (WIDTH - steps_c);
`else
  assign early_c = 1'b0;
  assign prod_c  = prod_raw_c;
`endif

  assign finish_c = last_c || early_c;

  // Sign-corrected results written to HI/LO at the finishing edge.
  logic [PW-1:0]    prod_s_c;
  logic [WIDTH-1:0] quot_c, rem_c, res_hi_c, res_lo_c;
  assign prod_s_c = neg_q ? -prod_c : prod_c;
  assign quot_c   = div0_q ? {WIDTH{1'b1}} : (neg_q ? -div_lsr_c : div_lsr_c);
  assign rem_c    = rneg_q ? -div_acc_c : div_acc_c;
  assign res_hi_c = mul_q ? prod_s_c[PW-1:WIDTH] : rem_c;
  assign res_lo_c = mul_q ? prod_s_c[WIDTH-1:0] : quot_c;

  // Sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lsr_d   = lsr_q;
    opnd_d  = opnd_q;
    mul_d   = mul_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d = S_RUN;
          cnt_d   = '0;
          acc_d   = '0;
          mul_d   = ~Funct[1];
          neg_d   = sa_c ^ sb_c;
          rneg_d  = sa_c;
          div0_d  = (b == '0);
          if (!Funct[1]) begin
            opnd_d = abs_a_c;
            lsr_d  = abs_b_c;
          end else begin
            opnd_d = abs_b_c;
            lsr_d  = abs_a_c;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = mul_q ? mul_acc_c : div_acc_c;
        lsr_d = mul_q ? mul_lsr_c : div_lsr_c;
        if (finish_c) begin
          state_d = S_IDLE;
          hi_d    = res_hi_c;
          lo_d    = res_lo_c;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lsr_q   <= '0;
      opnd_q  <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lsr_q   <= lsr_d;
      opnd_q  <= opnd_d;
      mul_q   <= mul_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign md_done = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md: decode sweep on both REG_OP builds,
// multiply/divide results and latency, stall behaviour, reset abort.
module tb_alu_control_md;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         valid;
  logic [1:0]   ALUOp;
  logic [5:0]   Funct;
  logic [W-1:0] a, b;

  logic [3:0]   Operation, r_Operation;
  logic [1:0]   md_sel, r_md_sel;
  logic         stall, r_stall;
  logic         md_busy, r_md_busy;
  logic         md_done, r_md_done;
  logic [W-1:0] hi, lo, r_hi, r_lo;

  int n_cmp = 0;
  int n_bad = 0;

  alu_control_md #(.WIDTH(W), .REG_OP(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .ALUOp(ALUOp), .Funct(Funct),
    .a(a), .b(b), .Operation(Operation), .md_sel(md_sel), .stall(stall),
    .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
  );

  alu_control_md #(.WIDTH(W), .REG_OP(1)) u_dut_r (
    .clk(clk), .rst_n(rst_n), .valid(valid), .ALUOp(ALUOp), .Funct(Funct),
    .a(a), .b(b), .Operation(r_Operation), .md_sel(r_md_sel), .stall(r_stall),
    .md_busy(r_md_busy), .md_done(r_md_done), .hi(r_hi), .lo(r_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_dec(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b00: return 4'b0010;
      2'b01: return 4'b0110;
      2'b11: return 4'b1111;
      default: begin
        case (f)
          6'b100000: return 4'b0010;
          6'b100001: return 4'b0010;
          6'b100010: return 4'b0110;
          6'b100011: return 4'b0110;
          6'b100100: return 4'b0000;
          6'b100101: return 4'b0001;
          6'b100110: return 4'b0011;
          6'b100111: return 4'b1100;
          6'b101010: return 4'b0111;
          6'b101011: return 4'b1000;
          default:   return 4'b1111;
        endcase
      end
    endcase
  endfunction

  function automatic logic [1:0] exp_sel(input logic [1:0] op, input logic [5:0] f);
    if (op != 2'b10) return 2'b00;
    if (f == 6'b010000) return 2'b01;
    if (f == 6'b010010) return 2'b10;
    return 2'b00;
  endfunction

  // Expected multiply latency for a multiplier magnitude m.
  function automatic int exp_mul_lat(input logic [31:0] m);
`ifdef MD_EARLY_OUT_EN
    int n;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n;
`else
    if (m == 32'hFFFF_FFFF) return 32;
    return 32;
`endif
  endfunction

  // Present a mult/div at posedge+1, check its start-cycle stall, pass edge E0.
  task automatic issue(input string tag, input logic [5:0] f, input logic [W-1:0] av,
                       input logic [W-1:0] bv);
    valid = 1'b1; ALUOp = 2'b10; Funct = f; a = av; b = bv;
    @(negedge clk);
    check_eq({tag, "_e0_stall"}, 64'(stall), 64'd1);
    check_eq({tag, "_e0_busy"}, 64'(md_busy), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Sample at negedges until md_done, counting busy and stall cycles.
  task automatic wait_done(input string tag, output int busy_c, output int stall_c);
    int n;
    n = 0; busy_c = 0; stall_c = 0;
    @(negedge clk);
    while (!md_done && n < 200) begin
      if (md_busy) busy_c++;
      if (stall) stall_c++;
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_done_seen"}, 64'(md_done), 64'd1);
  endtask

  // md_done must drop after one cycle; return to posedge+1 alignment.
  task automatic pulse_end(input string tag);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 64'(md_done), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int bc, sc, dc;
    logic [3:0] e, prev;
    valid = 1'b0; ALUOp = 2'b00; Funct = 6'd0; a = '0; b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    check_eq("rst_busy", 64'(md_busy), 64'd0);
    check_eq("rst_done", 64'(md_done), 64'd0);
    check_eq("rst_op_r", 64'(r_Operation), 64'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode sweep; the registered build lags one cycle.
    prev = 4'b0010;
    for (int op = 0; op < 4; op++) begin
      for (int f = 0; f < 64; f++) begin
        ALUOp = 2'(op); Funct = 6'(f);
        e = exp_dec(2'(op), 6'(f));
        @(negedge clk);
        check_eq("dec", 64'(Operation), 64'(e));
        check_eq("sel", 64'(md_sel), 64'(exp_sel(2'(op), 6'(f))));
        check_eq("dec_r_lag", 64'(r_Operation), 64'(prev));
        @(posedge clk); #1;
        check_eq("dec_r", 64'(r_Operation), 64'(e));
        prev = e;
      end
    end

    // Non-md R-type never stalls.
    valid = 1'b1; ALUOp = 2'b10; Funct = 6'b100111;
    @(negedge clk);
    check_eq("nor_op", 64'(Operation), 64'hC);
    check_eq("nor_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0;

    // MULT -3 * 5
    issue("mult", 6'b011000, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult", bc, sc);
    check_eq("mult_lat", 64'(bc), 64'(exp_mul_lat(32'd5)));
    check_eq("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check_eq("mult_lo", 64'(lo), 64'hFFFF_FFF1);
    pulse_end("mult");

    // MULTU 6*7 followed by MFLO held under stall
    issue("multu", 6'b011001, 32'd6, 32'd7);
    valid = 1'b1; Funct = 6'b010010;
    wait_done("mflo", bc, sc);
    check_eq("mflo_lat", 64'(bc), 64'(exp_mul_lat(32'd7)));
    check_eq("mflo_stall_cnt", 64'(sc), 64'(bc));
    check_eq("mflo_stall_end", 64'(stall), 64'd0);
    check_eq("mflo_sel", 64'(md_sel), 64'd2);
    check_eq("mflo_lo", 64'(lo), 64'd42);
    check_eq("mflo_hi", 64'(hi), 64'd0);
    valid = 1'b0;
    pulse_end("mflo");

    // Second MULT presented while busy must wait for IDLE
    issue("mu3", 6'b011001, 32'd3, 32'd3);
    valid = 1'b1; Funct = 6'b011000; a = 32'd5; b = 32'hFFFF_FFFE;
    wait_done("mu3", bc, sc);
    check_eq("mu3_lat", 64'(bc), 64'(exp_mul_lat(32'd3)));
    check_eq("mu3_stall_cnt", 64'(sc), 64'(bc));
    check_eq("mu3_lo", 64'(lo), 64'd9);
    check_eq("mu3_restall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    check_eq("m2_started", 64'(md_busy), 64'd1);
    wait_done("m2", bc, sc);
    check_eq("m2_lat", 64'(bc), 64'(exp_mul_lat(32'd2)));
    check_eq("m2_hi", 64'(hi), 64'hFFFF_FFFF);
    check_eq("m2_lo", 64'(lo), 64'hFFFF_FFF6);
    pulse_end("m2");

    // DIVU 100/7 with an add instruction alongside (no stall)
    issue("divu", 6'b011011, 32'd100, 32'd7);
    valid = 1'b1; Funct = 6'b100000;
    wait_done("divu", bc, sc);
    check_eq("divu_lat", 64'(bc), 64'd32);
    check_eq("divu_add_stall", 64'(sc), 64'd0);
    check_eq("divu_lo", 64'(lo), 64'd14);
    check_eq("divu_hi", 64'(hi), 64'd2);
    valid = 1'b0;
    pulse_end("divu");

    // DIV -7/2
    issue("div", 6'b011010, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", bc, sc);
    check_eq("div_lat", 64'(bc), 64'd32);
    check_eq("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check_eq("div_hi", 64'(hi), 64'hFFFF_FFFF);
    pulse_end("div");

    // DIVU by zero
    issue("div0", 6'b011011, 32'h1234, 32'd0);
    wait_done("div0", bc, sc);
    check_eq("div0_lat", 64'(bc), 64'd32);
    check_eq("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    check_eq("div0_hi", 64'(hi), 64'h1234);
    pulse_end("div0");

    // Reset in the middle of a DIV
    issue("abort", 6'b011010, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    check_eq("abort_busy_pre", 64'(md_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 64'(md_busy), 64'd0);
    check_eq("abort_hi", 64'(hi), 64'd0);
    check_eq("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_done) dc++;
    end
    check_eq("abort_no_done", 64'(dc), 64'd0);
    @(posedge clk); #1;

    // MULTU 7*3 (early-out build: two cycles)
    issue("eo", 6'b011001, 32'd7, 32'd3);
    wait_done("eo", bc, sc);
    check_eq("eo_lat", 64'(bc), 64'(exp_mul_lat(32'd3)));
    check_eq("eo_lo", 64'(lo), 64'd21);
    check_eq("eo_hi", 64'(hi), 64'd0);
    pulse_end("eo");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
